// File: rtl/display_timing_detector.sv
// Video timing detector: measures h/v totals and active sizes, locks on repeated identical frames,
// and emits de-aligned pixel coordinates. Optional sync polarity detection: DISPLAY_TIMING_DETECTOR_POL_EN.
module display_timing_detector #(
  parameter int unsigned CORDW       = 10,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic           clk_pix,
  input  logic           rst,
  input  logic           hsync_in,
  input  logic           vsync_in,
  input  logic           de_in,
  output logic           de_out,
  output logic [CORDW:0] sx,
  output logic [CORDW:0] sy,
  output logic [CORDW:0] h_total,
  output logic [CORDW:0] h_active,
  output logic [CORDW:0] v_total,
  output logic [CORDW:0] v_active,
  output logic           locked,
  output logic           hsync_pol,
  output logic           vsync_pol
);

  localparam int unsigned CW = CORDW + 1;
  localparam int unsigned MW = 4;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  typedef struct packed {
    logic [CW-1:0] ht;
    logic [CW-1:0] ha;
    logic [CW-1:0] vt;
    logic [CW-1:0] va;
  } timing_t;

  // Input registers plus one-cycle history for edge detection
  logic hs_r, vs_r, de_r;
  logic hs_q, vs_q, de_q;

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      hs_r <= 1'b0;
      vs_r <= 1'b0;
      de_r <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      hs_r <= hsync_in;
      vs_r <= vsync_in;
      de_r <= de_in;
      hs_q <= hs_r;
      vs_q <= vs_r;
      de_q <= de_r;
    end
  end

  logic de_rise, de_fall;
  assign de_rise = de_r & ~de_q;
  assign de_fall = de_q & ~de_r;

  logic hpol_q, vpol_q, pol_chg;

`ifdef DISPLAY_TIMING_DETECTOR_POL_EN
  // Sync level seen at the start of active video is the inactive level
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      hpol_q <= 1'b0;
      vpol_q <= 1'b0;
    end else if (de_rise) begin
      hpol_q <= ~hs_r;
      vpol_q <= ~vs_r;
    end
  end

  assign pol_chg = de_rise & ((~hs_r != hpol_q) | (~vs_r != vpol_q));
`else
  assign hpol_q  = 1'b0;
  assign vpol_q  = 1'b0;
  assign pol_chg = 1'b0;
`endif

  assign hsync_pol = hpol_q;
  assign vsync_pol = vpol_q;

  logic hs_act_r, hs_act_q, vs_act_r, vs_act_q;
  logic hs_lead, vs_lead;
  assign hs_act_r = hs_r ^ ~hpol_q;
  assign hs_act_q = hs_q ^ ~hpol_q;
  assign vs_act_r = vs_r ^ ~vpol_q;
  assign vs_act_q = vs_q ^ ~vpol_q;
  assign hs_lead  = hs_act_r & ~hs_act_q;
  assign vs_lead  = vs_act_r & ~vs_act_q;

  // Per-line and per-frame measurement counters
  logic [CW-1:0] line_cnt, line_de_cnt, h_len_last, h_act_last, v_cnt, v_act_cnt;
  logic          line_has_de;
  logic [CW-1:0] line_len;
  logic          line_sat;
  logic          new_de_line;

  assign line_len    = line_cnt + CW'(1);
  assign line_sat    = (line_cnt == CNT_MAX) & ~hs_lead;
  assign new_de_line = de_r & (hs_lead | ~line_has_de);

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      line_cnt    <= '0;
      line_de_cnt <= '0;
      line_has_de <= 1'b0;
      h_len_last  <= '0;
      h_act_last  <= '0;
      v_cnt       <= '0;
      v_act_cnt   <= '0;
    end else begin
      if (hs_lead) begin
        line_cnt    <= '0;
        h_len_last  <= line_len;
        line_de_cnt <= CW'(de_r);
        line_has_de <= de_r;
      end else begin
        if (line_cnt != CNT_MAX) line_cnt <= line_cnt + CW'(1);
        if (de_r) begin
          line_has_de <= 1'b1;
          if (line_de_cnt != CNT_MAX) line_de_cnt <= line_de_cnt + CW'(1);
        end
      end
      if (de_fall) h_act_last <= line_de_cnt;
      if (vs_lead) begin
        v_cnt     <= '0;
        v_act_cnt <= CW'(new_de_line);
      end else begin
        if (hs_lead && v_cnt != CNT_MAX) v_cnt <= v_cnt + CW'(1);
        if (new_de_line && v_act_cnt != CNT_MAX) v_act_cnt <= v_act_cnt + CW'(1);
      end
    end
  end

  // Frame measurement as seen at a vsync leading edge (a coincident line end is included)
  timing_t meas;
  always_comb begin
    meas    = '0;
    meas.ht = hs_lead ? line_len : h_len_last;
    meas.ha = h_act_last;
    meas.vt = v_cnt + CW'(hs_lead);
    meas.va = v_act_cnt;
  end

  // Pixel coordinate pipeline, aligned with de_out
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      de_out <= 1'b0;
      sx     <= '0;
      sy     <= '0;
    end else begin
      de_out <= de_r;
      if (de_r) sx <= de_q ? sx + CW'(1) : '0;
      if (vs_lead)      sy <= '0;
      else if (de_fall) sy <= sy + CW'(1);
    end
  end

  state_t        state, state_nxt, st_mid;
  timing_t       cand, cand_nxt, lock_q, lock_nxt;
  logic [MW-1:0] mcnt, mcnt_nxt;
  logic          locked_nxt;

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state  <= SEARCH;
      cand   <= '0;
      mcnt   <= '0;
      lock_q <= '0;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      cand   <= cand_nxt;
      mcnt   <= mcnt_nxt;
      lock_q <= lock_nxt;
      locked <= locked_nxt;
    end
  end

  // Line end is resolved before frame end; a stalled line counter overrides both
  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    mcnt_nxt   = mcnt;
    lock_nxt   = lock_q;
    locked_nxt = 1'b0;
    st_mid     = state;

    if (state == LOCKED && hs_lead && line_len != lock_q.ht) begin
      st_mid      = MEASURE;
      cand_nxt    = lock_q;
      cand_nxt.ht = line_len;
      mcnt_nxt    = MW'(1);
    end else if (state == LOCKED && pol_chg) begin
      st_mid   = MEASURE;
      mcnt_nxt = '0;
    end
    state_nxt = st_mid;

    if (vs_lead) begin
      case (st_mid)
        SEARCH: begin
          state_nxt = MEASURE;
          cand_nxt  = '0;
          mcnt_nxt  = '0;
        end
        MEASURE: begin
          if (meas == cand_nxt) begin
            mcnt_nxt = mcnt_nxt + MW'(1);
          end else begin
            cand_nxt = meas;
            mcnt_nxt = MW'(1);
          end
          if (mcnt_nxt >= MW'(LOCK_FRAMES)) begin
            state_nxt = LOCKED;
            lock_nxt  = cand_nxt;
          end
        end
        LOCKED: begin
          if (meas != lock_q) begin
            state_nxt = MEASURE;
            cand_nxt  = meas;
            mcnt_nxt  = MW'(1);
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end

    if (line_sat) begin
      state_nxt = SEARCH;
      cand_nxt  = '0;
      mcnt_nxt  = '0;
    end

    locked_nxt = (state_nxt == LOCKED);
  end

  assign h_total  = lock_q.ht;
  assign h_active = lock_q.ha;
  assign v_total  = lock_q.vt;
  assign v_active = lock_q.va;

endmodule

// File: tb/tb_display_timing_detector.sv
// Bench for display_timing_detector: scaled-down video modes, lock/unlock scenarios and a
// scoreboard of expected de_out/sx/sy checked two cycles after each driven pixel.
`timescale 1ns/1ps
module tb_display_timing_detector;

  localparam int unsigned CORDW = 10;

  logic clk_pix = 1'b0;
  logic rst = 1'b0;
  logic hsync_in, vsync_in, de_in;
  logic de_out, locked, hsync_pol, vsync_pol;
  logic [CORDW:0] sx, sy, h_total, h_active, v_total, v_active;

  display_timing_detector #(.CORDW(CORDW), .LOCK_FRAMES(2)) dut (
    .clk_pix  (clk_pix),
    .rst      (rst),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .de_in    (de_in),
    .de_out   (de_out),
    .sx       (sx),
    .sy       (sy),
    .h_total  (h_total),
    .h_active (h_active),
    .v_total  (v_total),
    .v_active (v_active),
    .locked   (locked),
    .hsync_pol(hsync_pol),
    .vsync_pol(vsync_pol)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    int ht, ha, hfp, hsw;
    int vt, va, vfp, vsw;
  } mode_t;

  typedef struct {
    int   kind;
    logic de;
    int   x;
    int   y;
  } exp_t;

  int    checks = 0;
  int    failures = 0;
  exp_t  sb[$];
  logic  model_ok = 1'b0;
  logic  pos_sync = 1'b0;
  mode_t mode_a, mode_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One pixel clock: retire the oldest expectation, then drive and queue the next pixel
  task automatic tick(input logic hs_act, input logic vs_act, input logic de,
                      input int kind, input int x, input int y);
    exp_t e;
    @(negedge clk_pix);
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      if (e.kind >= 1) check_eq("de_out", 32'(de_out), 32'(e.de));
      if (e.kind == 2) begin
        check_eq("sx", 32'(sx), 32'(e.x));
        check_eq("sy", 32'(sy), 32'(e.y));
      end
    end
    if (rst) rst = 1'b0;
    hsync_in = pos_sync ? hs_act : ~hs_act;
    vsync_in = pos_sync ? vs_act : ~vs_act;
    de_in    = de;
    e.kind = model_ok ? kind : 0;
    e.de   = de;
    e.x    = x;
    e.y    = y;
    sb.push_back(e);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_locked",   32'(locked),   32'd0);
    check_eq("rst_h_total",  32'(h_total),  32'd0);
    check_eq("rst_h_active", 32'(h_active), 32'd0);
    check_eq("rst_v_total",  32'(v_total),  32'd0);
    check_eq("rst_v_active", 32'(v_active), 32'd0);
    sb.delete();
    model_ok = 1'b0;
  endtask

  task automatic drive_frame(input mode_t m, input int lines, input int rst_line,
                             input int probe_line, input logic probe_exp);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < m.ht; x++) begin
        logic hs, vs, de;
        int   kind;
        hs = (x >= m.ha + m.hfp) && (x < m.ha + m.hfp + m.hsw);
        vs = (y >= m.va + m.vfp) && (y < m.va + m.vfp + m.vsw);
        de = (y < m.va) && (x < m.ha);
        if (x == 0 && y == m.va + m.vfp) model_ok = 1'b1;
        kind = 0;
        if (y < m.va && (y == 0 || y == m.va / 2 || y == m.va - 1)) begin
          if (x == 0 || x == m.ha - 1) kind = 2;
          else if (x == m.ha)          kind = 1;
        end
        tick(hs, vs, de, kind, x, y);
        if (y == rst_line && x == 10) pulse_reset();
      end
      if (y == probe_line) check_eq("locked_line", 32'(locked), 32'(probe_exp));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic check_timing(input mode_t m);
    check_eq("h_total",  32'(h_total),  32'(m.ht));
    check_eq("h_active", 32'(h_active), 32'(m.ha));
    check_eq("v_total",  32'(v_total),  32'(m.vt));
    check_eq("v_active", 32'(v_active), 32'(m.va));
  endtask

  task automatic frame_then(input mode_t m, input string tag, input logic exp_locked);
    drive_frame(m, m.vt, -1, -1, 1'b0);
    check_eq(tag, 32'(locked), 32'(exp_locked));
  endtask

  initial begin
    mode_a = '{ht: 50, ha: 32, hfp: 4, hsw: 6, vt: 20, va: 16, vfp: 1, vsw: 1};
    mode_b = '{ht: 66, ha: 40, hfp: 5, hsw: 8, vt: 24, va: 20, vfp: 1, vsw: 2};
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    de_in    = 1'b0;

    #1 rst = 1'b1;
    #2;
    check_eq("rst_locked",   32'(locked),    32'd0);
    check_eq("rst_h_total",  32'(h_total),   32'd0);
    check_eq("rst_h_active", 32'(h_active),  32'd0);
    check_eq("rst_v_total",  32'(v_total),   32'd0);
    check_eq("rst_v_active", 32'(v_active),  32'd0);
    check_eq("rst_de_out",   32'(de_out),    32'd0);
    check_eq("rst_sx",       32'(sx),        32'd0);
    check_eq("rst_sy",       32'(sy),        32'd0);
    check_eq("rst_hpol",     32'(hsync_pol), 32'd0);
    check_eq("rst_vpol",     32'(vsync_pol), 32'd0);

    // Initial lock: first vsync enters MEASURE, two full frames later LOCKED
    frame_then(mode_a, "lock_a_f1", 1'b0);
    frame_then(mode_a, "lock_a_f2", 1'b0);
    frame_then(mode_a, "lock_a_f3", 1'b1);
    check_timing(mode_a);
    frame_then(mode_a, "lock_a_hold", 1'b1);

    // Reset mid-frame while locked
    drive_frame(mode_a, mode_a.vt, 5, -1, 1'b0);
    check_eq("relock_f0", 32'(locked), 32'd0);
    frame_then(mode_a, "relock_f1", 1'b0);
    frame_then(mode_a, "relock_f2", 1'b1);
    check_timing(mode_a);

    // Mode switch: first mismatching line drops lock
    drive_frame(mode_b, mode_b.vt, -1, 0, 1'b0);
    check_eq("switch_b_f1", 32'(locked), 32'd0);
    frame_then(mode_b, "switch_b_f2", 1'b1);
    check_timing(mode_b);
    frame_then(mode_b, "switch_b_hold", 1'b1);

    drive_frame(mode_a, mode_a.vt, -1, 0, 1'b0);
    frame_then(mode_a, "back_a_f2", 1'b1);
    check_timing(mode_a);

    // One frame interval one line short
    drive_frame(mode_a, mode_a.vt - 1, -1, -1, 1'b0);
    check_eq("short_prev", 32'(locked), 32'd1);
    frame_then(mode_a, "short_f1", 1'b0);
    frame_then(mode_a, "short_f2", 1'b0);
    frame_then(mode_a, "short_f3", 1'b1);
    check_timing(mode_a);

    // hsync missing long enough to saturate the line counter
    idle(2100);
    check_eq("nohsync_locked", 32'(locked), 32'd0);
    frame_then(mode_a, "nohsync_f1", 1'b0);
    frame_then(mode_a, "nohsync_f2", 1'b0);
    frame_then(mode_a, "nohsync_f3", 1'b1);
    check_timing(mode_a);

`ifdef DISPLAY_TIMING_DETECTOR_POL_EN
    pos_sync = 1'b1;
    model_ok = 1'b0;
    for (int f = 0; f < 4; f++) drive_frame(mode_a, mode_a.vt, -1, -1, 1'b0);
    check_eq("pos_locked", 32'(locked),    32'd1);
    check_eq("pos_hpol",   32'(hsync_pol), 32'd1);
    check_eq("pos_vpol",   32'(vsync_pol), 32'd1);
    check_timing(mode_a);
`else
    check_eq("neg_hpol", 32'(hsync_pol), 32'd0);
    check_eq("neg_vpol", 32'(vsync_pol), 32'd0);
`endif

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_timing_detector.md
DISPLAY_TIMING_DETECTOR -- requirements
Module: display_timing_detector

Interface
REQ-001 SHALL have parameter CORDW, default 10: coordinate width; all counts and coordinates are CORDW+1 bits.
REQ-002 SHALL have parameter LOCK_FRAMES, default 2: consecutive identical frames required to lock (1..15).
REQ-003 SHALL have ports:
- clk_pix  in  1  pixel clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- de_in  in  1  data enable.
- de_out  out  1  de_in delayed to align with sx/sy.
- sx  out  CORDW+1  pixel index within active line.
- sy  out  CORDW+1  active line index within frame.
- h_total, h_active, v_total, v_active  out  CORDW+1 each  locked timing measurements.
- locked  out  1  timing stable.
- hsync_pol, vsync_pol  out  1 each  1 = positive sync.

Function
REQ-004 SHALL register all inputs once; sync leading edge = transition to the active level.
REQ-005 SHALL produce de_out, sx, sy exactly 2 cycles after the corresponding de_in.
REQ-006 sx SHALL be 0 on the first de cycle of a line and increment each de cycle; sy SHALL reset to 0 at vsync leading edge and increment on each de falling edge.
REQ-007 Line counter SHALL clear at hsync leading edge and saturate at all-ones; measured h_total = cycles between consecutive hsync leading edges.
REQ-008 Measured h_active = de-high cycles on the last line containing de before vsync leading edge; measured v_total = hsync leading edges between vsync leading edges; measured v_active = lines with at least one de cycle.
REQ-009 SHALL implement FSM SEARCH, MEASURE, LOCKED.
REQ-010 SEARCH -> MEASURE at first vsync leading edge; partial-frame data discarded; candidate cleared, match count 0.
REQ-011 MEASURE, each vsync leading edge: measurement equals candidate -> match count+1, else candidate reloaded and match count = 1; match count reaching LOCK_FRAMES -> LOCKED.
REQ-012 On LOCKED entry, h_total/h_active/v_total/v_active SHALL load the candidate and hold until the next LOCKED entry or reset.
REQ-013 LOCKED -> MEASURE when any line length differs from h_total at an hsync leading edge, or the frame measurement differs at vsync leading edge; locked deasserts the next cycle; offending measurement becomes candidate with match count 1.
REQ-014 Any state -> SEARCH when the line counter saturates (no hsync); locked = 0.
REQ-015 locked SHALL be 1 only in LOCKED.
REQ-016 Simultaneous hsync and vsync leading edges SHALL process line end first, then frame end.

Reset
REQ-017 rst SHALL asynchronously force SEARCH; all outputs, counters, candidate and match count to 0.
REQ-018 Reset mid-frame SHALL require full relock per REQ-010/011.

Configuration
REQ-019 Macro DISPLAY_TIMING_DETECTOR_POL_EN:
- defined: sync level sampled at every de rising edge is the inactive level; hsync_pol/vsync_pol = inverse of that level; a polarity change while LOCKED -> MEASURE.
- undefined: syncs treated as negative polarity; hsync_pol = vsync_pol = 0 constant.

Verification
REQ-020 SHALL cover:
- 800x525 stream, 640x480 active, negative syncs, LOCK_FRAMES=2 -> locked=1 after second full frame past first vsync edge; h_total=800, h_active=640, v_total=525, v_active=480; sx 0..639, sy 0..479.
- rst pulsed mid-frame while locked -> locked=0, all measurements 0 asynchronously; relock after 2 full frames.
- Switch to 1056x628 (800x600 active) -> locked falls after first 1056-cycle line; relocks with 1056/800/628/600.
- hsync held inactive 2048 cycles while locked -> state SEARCH, locked=0.
- One frame with 524 lines while locked -> locked falls at that vsync edge; relocks after next 2 identical 525-line frames.
- With DISPLAY_TIMING_DETECTOR_POL_EN, positive-sync 640x480 stream -> hsync_pol=1, vsync_pol=1, same locked values.
